fpnew_sdotp_result_fifo: RTL

Output-side buffer placed directly downstream of the SDOTP multi-format lane. It captures each completed result beat (result, status, extension bit, tag, aux) into a small circular FIFO. This decouples the SDOTP pipeline's out_ready_i from the consumer (writeback/regfile arbiter), so back-pressure no longer stalls the pipeline for transient conflicts. It also accumulates sticky FP exception flags for popped results.

---
 rtl/fpnew_sdotp_result_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fpnew_sdotp_result_fifo.sv
// Result FIFO behind the SDOTP lane: buffers result beats, decouples
// lane back-pressure from the consumer and keeps sticky FP flags.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   in_*  / in_valid_i      beat from the SDOTP lane
//   in_ready_o              FIFO not full
//   out_* / out_valid_o     head entry towards the consumer
//   out_ready_i             consumer accepts the head entry
//   flush_i                 drop every stored entry
//   fflags_o, clr_fflags_i  sticky OR of popped status, and its clear
//   count_o, busy_o         occupancy and non-empty indication
module fpnew_sdotp_result_fifo #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 2,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [Width-1:0]         in_result_i,
    input  logic [4:0]               in_status_i,
    input  logic                     in_ext_bit_i,
    input  TagType                   in_tag_i,
    input  AuxType                   in_aux_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [Width-1:0]         out_result_o,
    output logic [4:0]               out_status_o,
    output logic                     out_ext_bit_o,
    output TagType                   out_tag_o,
    output AuxType                   out_aux_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [4:0]               fflags_o,
    input  logic                     clr_fflags_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     busy_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(Depth);

    logic [Width-1:0] result_q [Depth];
    logic [4:0]       status_q [Depth];
    logic             ext_q    [Depth];
    TagType           tag_q    [Depth];
    AuxType           aux_q    [Depth];

    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic [4:0]    fflags_q;

    logic push;
    logic pop;
    logic pop_acc;

    // Ready/valid depend on the registered count only, so the
    // consumer's ready never reaches the lane combinationally.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign busy_o      = out_valid_o;
    assign count_o     = count_q;
    assign fflags_o    = fflags_q;

    assign push    = in_valid_i && in_ready_o;
    assign pop     = out_valid_o && out_ready_i;
    // A flushed pop is discarded, so its status is not accumulated.
    assign pop_acc = pop && !flush_i;

    assign out_result_o  = result_q[rd_q];
    assign out_status_o  = status_q[rd_q];
    assign out_ext_bit_o = ext_q[rd_q];
    assign out_tag_o     = tag_q[rd_q];
    assign out_aux_o     = aux_q[rd_q];

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            result_q[wr_q] <= in_result_i;
            status_q[wr_q] <= in_status_i;
            ext_q[wr_q]    <= in_ext_bit_i;
            tag_q[wr_q]    <= in_tag_i;
            aux_q[wr_q]    <= in_aux_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Clear together with a pop keeps the popped flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else if (clr_fflags_i) begin
            fflags_q <= pop_acc ? out_status_o : 5'b0;
        end else if (pop_acc) begin
            fflags_q <= fflags_q | out_status_o;
        end
    end

    a_no_push_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == FULL));

    a_count_max : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        count_q <= FULL);

    a_head_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=>
        ($stable(out_result_o) && $stable(out_status_o) &&
         $stable(out_ext_bit_o) && $stable(out_tag_o) &&
         $stable(out_aux_o)));

endmodule
